// File: rtl/axis_read_data_if.sv
// axis_read_data_if: config, AXI R-channel and user
// stream signals of the read data path.
interface axis_read_data_if #(
  parameter int CFG_DWIDTH     = 32,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int DATA_WIDTH     = 32
);
  logic [CFG_DWIDTH-1:0]     cfg_length;
  logic                      cfg_valid;
  logic                      cfg_ready;
  logic [AXI_DATA_WIDTH-1:0] axi_rdata;
  logic                      axi_rlast;
  logic                      axi_rvalid;
  logic                      axi_rready;
  logic [DATA_WIDTH-1:0]     data;
  logic                      valid;
  logic                      ready;

  modport slave (
    input  cfg_length, cfg_valid,
    input  axi_rdata, axi_rlast, axi_rvalid,
    input  ready,
    output cfg_ready, axi_rready,
    output data, valid
  );

  modport master (
    output cfg_length, cfg_valid,
    output axi_rdata, axi_rlast, axi_rvalid,
    output ready,
    input  cfg_ready, axi_rready,
    input  data, valid
  );
endinterface

// File: rtl/axis_read_data.sv
// axis_read_data: splits AXI read beats into words and
// delivers exactly cfg_length words on a valid/ready stream.
module axis_read_data #(
  parameter int BUF_AWIDTH     = 9,
  parameter int CFG_DWIDTH     = 32,
  parameter int WIDTH_RATIO    = 2,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int DATA_WIDTH     = 32
) (
  input logic             clk,
  input logic             rst_n,
  axis_read_data_if.slave bus
);
  localparam int RW    = $clog2(WIDTH_RATIO);
  localparam int SW    = RW + 1;
  localparam int FW    = BUF_AWIDTH + 1;
  localparam int DEPTH = 1 << BUF_AWIDTH;
  localparam int CW    = CFG_DWIDTH;

  typedef enum logic [2:0] {
    S_IDLE   = 3'b001,
    S_ACTIVE = 3'b010,
    S_DONE   = 3'b100
  } state_t;

  state_t                    state_q, state_d;
  logic [CW-1:0]             len_q, len_d;
  logic [CW-1:0]             beats_q, beats_d;
  logic [CW-1:0]             beat_cnt_q, beat_cnt_d;
  logic [CW-1:0]             word_cnt_q, word_cnt_d;
  logic [CW:0]               widx_q, widx_d;
  logic [AXI_DATA_WIDTH-1:0] ser_q, ser_d;
  logic [SW-1:0]             ser_left_q, ser_left_d;
  logic [BUF_AWIDTH-1:0]     wr_ptr_q, wr_ptr_d;
  logic [BUF_AWIDTH-1:0]     rd_ptr_q, rd_ptr_d;
  logic [FW-1:0]             mem_cnt_q, mem_cnt_d;
  logic                      out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]     out_data_q, out_data_d;
  logic [DATA_WIDTH-1:0]     mem [DEPTH];

  logic          active, rready, take, emit, push, pop, mem_rd;
  logic [FW-1:0] used;
  logic          unused_rlast;

  assign unused_rlast = bus.axi_rlast;
  assign active = (state_q == S_ACTIVE);

  // Serializer words still to come count as reserved FIFO space.
  assign used = mem_cnt_q + FW'(out_valid_q) + FW'(ser_left_q);

  assign rready = active
                & (beat_cnt_q < beats_q)
                & (ser_left_q <= SW'(1))
                & (used <= FW'(DEPTH - WIDTH_RATIO));
  assign take   = rready & bus.axi_rvalid;
  assign emit   = active & (ser_left_q != '0);
  assign push   = emit & (widx_q < {1'b0, len_q});
  assign pop    = out_valid_q & bus.ready;
  assign mem_rd = active & (~out_valid_q | pop)
                & (mem_cnt_q != '0);

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    beats_d     = beats_q;
    beat_cnt_d  = beat_cnt_q;
    word_cnt_d  = word_cnt_q;
    widx_d      = widx_q;
    ser_d       = ser_q;
    ser_left_d  = ser_left_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    mem_cnt_d   = mem_cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;

    if (active) begin
      if (take) begin
        ser_d      = bus.axi_rdata;
        ser_left_d = SW'(WIDTH_RATIO);
        beat_cnt_d = beat_cnt_q + CW'(1);
      end else if (emit) begin
        ser_d      = ser_q >> DATA_WIDTH;
        ser_left_d = ser_left_q - SW'(1);
      end
      if (emit) widx_d = widx_q + (CW+1)'(1);
      if (push) wr_ptr_d = wr_ptr_q + BUF_AWIDTH'(1);
      if (pop) word_cnt_d = word_cnt_q + CW'(1);
      if (~out_valid_q | pop) out_valid_d = 1'b0;
      if (mem_rd) begin
        out_valid_d = 1'b1;
        out_data_d  = mem[rd_ptr_q];
        rd_ptr_d    = rd_ptr_q + BUF_AWIDTH'(1);
      end
      mem_cnt_d = mem_cnt_q + FW'(push) - FW'(mem_rd);
    end else begin
      ser_left_d  = '0;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      mem_cnt_d   = '0;
      out_valid_d = 1'b0;
      out_data_d  = '0;
    end

    unique case (state_q)
      S_IDLE: begin
        if (bus.cfg_valid) begin
          len_d      = bus.cfg_length;
          beats_d    = (bus.cfg_length >> RW)
                     + CW'(|bus.cfg_length[RW-1:0]);
          beat_cnt_d = '0;
          word_cnt_d = '0;
          widx_d     = '0;
          state_d    = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        if (len_q == '0) state_d = S_DONE;
        else if (pop && (word_cnt_q + CW'(1) == len_q))
          state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      beats_q     <= '0;
      beat_cnt_q  <= '0;
      word_cnt_q  <= '0;
      widx_q      <= '0;
      ser_q       <= '0;
      ser_left_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      mem_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      beats_q     <= beats_d;
      beat_cnt_q  <= beat_cnt_d;
      word_cnt_q  <= word_cnt_d;
      widx_q      <= widx_d;
      ser_q       <= ser_d;
      ser_left_q  <= ser_left_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      mem_cnt_q   <= mem_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= ser_q[DATA_WIDTH-1:0];
  end

  assign bus.cfg_ready  = (state_q == S_IDLE);
  assign bus.axi_rready = rready;
  assign bus.valid      = out_valid_q;
  assign bus.data       = out_data_q;
endmodule

// File: tb/tb_axis_read_data.sv
// tb_axis_read_data: random AXI beats and consumer
// stalls checked against a word-queue reference model.
module tb_axis_read_data;
  localparam int AW    = 4;
  localparam int R     = 2;
  localparam int DEPTH = 1 << AW;
  localparam int DW    = 32;
  localparam int ADW   = 64;
  localparam int CW    = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  int   last_dur = 0;
  int   dur_a;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  axis_read_data_if #(
    .CFG_DWIDTH(CW), .AXI_DATA_WIDTH(ADW), .DATA_WIDTH(DW)
  ) bus ();

  axis_read_data #(
    .BUF_AWIDTH(AW), .CFG_DWIDTH(CW), .WIDTH_RATIO(R),
    .AXI_DATA_WIDTH(ADW), .DATA_WIDTH(DW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.slave)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [ADW-1:0] new_beat(input int b,
                                              input int mode);
    logic [ADW-1:0] v;
    v = '0;
    if (mode == 0) begin
      for (int i = 0; i < R; i++)
        v[i*DW +: DW] = 32'(b * R + i) * 32'h1111_1111;
    end else begin
      v = {$urandom, $urandom};
    end
    return v;
  endfunction

  // mode 0: rvalid always 1, pattern data; 1: random
  // rmode 0: ready=1; 1: one cycle in three; 2: random
  task automatic run_stream(input int len, input int mode,
                            input int rmode, input bit rlast_en,
                            input int abort_at);
    logic [DW-1:0]  q[$];
    logic [ADW-1:0] beat;
    logic [DW-1:0]  hold_d;
    int beats_acc, popped, exp_beats, busy, start, end_c, capped;
    int first_acc, first_val, first_pop, last_pop;
    bit done, seen_busy, hold;
    beats_acc = 0; popped = 0; busy = 0; end_c = 0;
    first_acc = -1; first_val = -1;
    first_pop = -1; last_pop = -1;
    done = 0; seen_busy = 0; hold = 0; hold_d = '0;
    exp_beats = (len + R - 1) / R;
    beat = new_beat(0, mode);

    @(posedge clk); #1;
    bus.cfg_length = CW'(len);
    bus.cfg_valid  = 1'b1;
    @(posedge clk); #1;
    bus.cfg_valid = 1'b0;
    start = cyc;

    for (int t = 0; t < 20000 && !done; t++) begin
      bus.axi_rvalid = (mode == 0) ? 1'b1
                     : ($urandom_range(0, 3) != 0);
      bus.axi_rdata  = beat;
      bus.axi_rlast  = rlast_en && (beats_acc % 2 == 1);
      case (rmode)
        0:       bus.ready = 1'b1;
        1:       bus.ready = (t % 3 == 0);
        default: bus.ready = 1'($urandom_range(0, 1));
      endcase
      @(negedge clk);

      if (!bus.cfg_ready) begin
        seen_busy = 1;
        busy++;
      end
      if (hold) begin
        chk("hold_valid", 64'(bus.valid), 64'd1);
        chk("hold_data", 64'(bus.data), 64'(hold_d));
      end
      hold   = bus.valid && !bus.ready;
      hold_d = bus.data;
      if (bus.valid && first_val < 0) first_val = cyc;

      capped = beats_acc * R;
      if (capped > len) capped = len;
      if (bus.axi_rready)
        chk("rready_space",
            64'((capped - popped) <= DEPTH - R + 1), 64'd1);
      if (bus.axi_rvalid && beats_acc >= exp_beats)
        chk("rready_after_last", 64'(bus.axi_rready), 64'd0);

      if (bus.axi_rvalid && bus.axi_rready) begin
        if (first_acc < 0) first_acc = cyc;
        for (int i = 0; i < R; i++)
          if (beats_acc * R + i < len)
            q.push_back(beat[i*DW +: DW]);
        beats_acc++;
        beat = new_beat(beats_acc, mode);
      end

      if (bus.valid && bus.ready) begin
        chk("word_avail", 64'(q.size() > 0), 64'd1);
        if (q.size() > 0)
          chk("data", 64'(bus.data), 64'(q.pop_front()));
        popped++;
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
        if (abort_at >= 0 && popped == abort_at) begin
          @(posedge clk); #1;
          rst_n = 1'b0;
          bus.axi_rvalid = 1'b0;
          bus.ready = 1'b0;
          @(posedge clk); #1;
          rst_n = 1'b1;
          @(negedge clk);
          chk("rst_valid", 64'(bus.valid), 64'd0);
          chk("rst_rready", 64'(bus.axi_rready), 64'd0);
          chk("rst_cfg_ready", 64'(bus.cfg_ready), 64'd1);
          return;
        end
      end

      if (seen_busy && bus.cfg_ready) begin
        done  = 1;
        end_c = cyc;
        chk("idle_valid", 64'(bus.valid), 64'd0);
      end else begin
        @(posedge clk); #1;
      end
    end

    bus.axi_rvalid = 1'b0;
    bus.axi_rlast  = 1'b0;
    chk("stream_done", 64'(done), 64'd1);
    chk("words", 64'(popped), 64'(len));
    chk("beats", 64'(beats_acc), 64'(exp_beats));
    chk("leftover", 64'(q.size()), 64'd0);
    if (first_acc >= 0)
      chk("latency", 64'(first_val - first_acc), 64'd3);
    if (mode == 0 && len > 0) begin
      chk("gapless", 64'(last_pop - first_pop), 64'(len - 1));
      chk("cfg_ready_back", 64'(end_c - last_pop), 64'd2);
    end
    if (len == 0) chk("busy_cycles", 64'(busy), 64'd2);
    last_dur = end_c - start;
  endtask

  initial begin
    bus.cfg_length = '0;
    bus.cfg_valid  = 1'b0;
    bus.axi_rdata  = '0;
    bus.axi_rlast  = 1'b0;
    bus.axi_rvalid = 1'b0;
    bus.ready      = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_cfg_ready", 64'(bus.cfg_ready), 64'd1);
    chk("reset_valid", 64'(bus.valid), 64'd0);
    chk("reset_rready", 64'(bus.axi_rready), 64'd0);
    chk("reset_data", 64'(bus.data), 64'd0);

    run_stream(8, 0, 0, 0, -1);
    run_stream(5, 0, 0, 0, -1);
    run_stream(1000, 1, 1, 0, -1);
    run_stream(0, 0, 0, 0, -1);
    run_stream(16, 1, 2, 0, 3);
    run_stream(4, 1, 0, 0, -1);

    run_stream(16, 0, 0, 1, -1);
    dur_a = last_dur;
    run_stream(16, 0, 0, 0, -1);
    chk("rlast_timing", 64'(last_dur), 64'(dur_a));

    repeat (6)
      run_stream($urandom_range(1, 40), 1, 2,
                 1'($urandom_range(0, 1)), -1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/axis_read_data.md
# axis_read_data

Read-side counterpart of the AXI write data path: accepts AXI read data-channel beats of AXI_DATA_WIDTH bits, splits each into WIDTH_RATIO words of DATA_WIDTH bits, and delivers exactly cfg_length words on a valid/ready stream. It sits between the AXI HP port's R channel and the user stream interface of the read-side AXIS engine. The read address issuer runs beside it and is configured with the same length.

## Interface
- BUF_AWIDTH, 9: log2 depth of the output word FIFO.
- CFG_DWIDTH, 32: width of cfg_length and the internal word and beat counters.
- WIDTH_RATIO, 2: words per AXI beat, a power of two ≥ 2; equals AXI_DATA_WIDTH/DATA_WIDTH.
- AXI_DATA_WIDTH, 64: AXI read data width.
- DATA_WIDTH, 32: user stream word width.

- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- cfg_length  in  CFG_DWIDTH  number of DATA_WIDTH words in the stream.
- cfg_valid  in  1  configuration strobe.
- cfg_ready  out  1  block idle; configuration is accepted.
- axi_rdata  in  AXI_DATA_WIDTH  AXI read data.
- axi_rlast  in  1  AXI burst end; not used for control.
- axi_rvalid  in  1  AXI beat valid.
- axi_rready  out  1  AXI beat accept.
- data  out  DATA_WIDTH  stream word.
- valid  out  1  stream word valid.
- ready  in  1  stream consumer ready.

## Operation
- One-hot state register with three states: IDLE, ACTIVE, DONE.
  - IDLE: cfg_ready=1. On cfg_valid, latch len=cfg_length and beats=ceil(len/WIDTH_RATIO), clear all counters and go to ACTIVE.
  - ACTIVE: runs until word_cnt==len, then goes to DONE. If len==0, go straight to DONE; no beat is accepted.
  - DONE: one cycle, then IDLE. The FIFO and serializer are flushed.
- The FIFO and serializer are held in reset while in IDLE.
- Beat acceptance:
  - A beat is taken on axi_rvalid & axi_rready.
  - axi_rready = ACTIVE & (beat_cnt < beats) & serializer able to load & FIFO free space ≥ WIDTH_RATIO.
  - The serializer is able to load when it is empty or is emitting its last word this cycle.
  - beat_cnt increments on each accepted beat.
- Serializer:
  - Holds one beat and emits word i = axi_rdata[i*DATA_WIDTH +: DATA_WIDTH], i=0 first.
  - Emits one word per cycle into the FIFO.
  - Words whose global index is ≥ len are dropped, not pushed. This covers the tail of the final beat when len is not a multiple of WIDTH_RATIO.
- Output FIFO:
  - First-word-fall-through.
  - valid = ~empty; data = head word.
  - Pop on valid & ready; word_cnt increments on each pop.
- axi_rlast is ignored. The beat count alone ends the AXI side, so a stream may span any number of bursts.
- Beats presented after beat_cnt==beats are not accepted: axi_rready stays 0.
- cfg_valid outside IDLE is ignored.

## Timing
- Reset (rst_n=0 at an edge):
  - state becomes IDLE; cfg_ready=1 from the next cycle.
  - axi_rready=0, valid=0, data=0.
  - FIFO empty; all counters 0.
  - Reset mid-stream discards all buffered words and in-flight beats.
- Configuration: cfg_valid sampled in IDLE → ACTIVE the next cycle. axi_rready can rise in the first ACTIVE cycle.
- Latency: a beat accepted at edge N produces word 0 with valid=1 after edge N+2. Word k of that beat follows k cycles later, provided the FIFO was empty and ready=1.
- Throughput: with ready=1 and rvalid=1, sustain one word per cycle. That is one beat every WIDTH_RATIO cycles; axi_rready pulses for 1 of every WIDTH_RATIO cycles.
- Backpressure:
  - ready=0 holds data/valid stable.
  - The FIFO fills, and axi_rready stays 0 while free space < WIDTH_RATIO.
  - No word is lost or duplicated.
- Full/empty edge case: a simultaneous push and pop at count=2^BUF_AWIDTH−WIDTH_RATIO must not deassert axi_rready spuriously. The free-space check uses the registered count.
- The last pop (word_cnt reaches len) moves the state to DONE at that edge. valid=0 in DONE and in IDLE.
- Counter wrap: counters are CFG_DWIDTH wide. cfg_length up to 2^CFG_DWIDTH−1 is supported with no overflow in the ceil computation.

## Test plan
- len=8, ratio 2, beats 0x1111_1111_0000_0000 … 0x7777_7777_6666_6666, ready=1:
  - Expect data 0,1111_1111,…,7777_7777 in order, 4 beats accepted.
  - First valid 2 cycles after the first accept; cfg_ready=1 two cycles after the last pop.
- len=5, ratio 2:
  - Exactly 3 beats accepted; 5 words delivered.
  - The upper half of beat 3 is never output; a 4th beat offered with rvalid=1 sees axi_rready=0.
- len=1000, BUF_AWIDTH=4, ready toggling 1-of-3 cycles:
  - All 1000 words arrive in order with no gaps or duplicates.
  - axi_rready=0 whenever FIFO free space < 2.
- len=0:
  - IDLE→ACTIVE→DONE→IDLE; axi_rready and valid stay 0 throughout.
- rst_n=0 after 3 words of a len=16 stream:
  - Next cycle valid=0, axi_rready=0, cfg_ready=1.
  - A new len=4 stream then delivers only new-beat data.
- axi_rlast asserted every 2 beats, len=16:
  - Behaviour identical to rlast tied 0.
